tanh_series_core: RTL and testbench

Parametrised fixed-point tanh(x) evaluator using a truncated Maclaurin series, computed by Horner's rule on x² with one shared signed multiplier. It is the next generation of the single-format tanh Top block. Term count and I/O formats are parameters, and a busy flag is added. It sits behind the start/done handshake of the datapath controller. It accepts one operand per request and holds the result until the next completion.

---
 rtl/tanh_series_if.sv | 14 +
 rtl/tanh_series_core.sv | 144 ++++++++++++++
 tb/tb_tanh_series_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tanh_series_if.sv
// Start/done handshake bundle between the datapath controller and tanh_series_core.
interface tanh_series_if #(
    parameter int X_W   = 17,
    parameter int RES_W = 32
);
    logic                    start;
    logic signed [X_W-1:0]   data_x;
    logic                    busy;
    logic                    done;
    logic signed [RES_W-1:0] result;

    modport master (output start, data_x, input busy, done, result);
    modport slave  (input start, data_x, output busy, done, result);
endinterface

// File: rtl/tanh_series_core.sv
// Fixed-point tanh(x) by a truncated Maclaurin series in x^2 (Horner's rule, one shared multiplier).
// Optional build macro TANH_ODD_FOLD_EN: evaluate on |x| and restore the sign, giving exact odd symmetry.
module tanh_series_core #(
    parameter int X_W      = 17,
    parameter int X_FRAC   = 16,
    parameter int RES_W    = 32,
    parameter int RES_FRAC = 30,
    parameter int N_TERMS  = 5
) (
    input  logic          clk,
    input  logic          rst,
    tanh_series_if.slave  bus
);
    localparam int SHIFT = RES_FRAC - X_FRAC;
    localparam logic [2:0] K_INIT = (N_TERMS > 1) ? 3'(N_TERMS - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, SQR, HORNER, FINAL} state_t;

    // Series coefficient k rounded to nearest (ties away from zero) in Q.RES_FRAC.
    function automatic logic signed [RES_W-1:0] coef_fn(input int idx);
        longint num, den, mag, q;
        case (idx)
            0:       begin num = 1;       den = 1;         end
            1:       begin num = -1;      den = 3;         end
            2:       begin num = 2;       den = 15;        end
            3:       begin num = -17;     den = 315;       end
            4:       begin num = 62;      den = 2835;      end
            5:       begin num = -1382;   den = 155925;    end
            6:       begin num = 21844;   den = 6081075;   end
            default: begin num = -929569; den = 638512875; end
        endcase
        mag = (num < 0) ? -num : num;
        q   = ((mag << (RES_FRAC + 1)) + den) / (2 * den);
        return (num < 0) ? RES_W'(-q) : RES_W'(q);
    endfunction

    localparam logic signed [RES_W-1:0] COEF [8] = '{
        coef_fn(0), coef_fn(1), coef_fn(2), coef_fn(3),
        coef_fn(4), coef_fn(5), coef_fn(6), coef_fn(7)
    };

    // Full-width signed product, floor shift by RES_FRAC, wrap to RES_W.
    function automatic logic signed [RES_W-1:0] mul(input logic signed [RES_W-1:0] a,
                                                     input logic signed [RES_W-1:0] b);
        logic signed [2*RES_W-1:0] ax, bx, p;
        ax = {{RES_W{a[RES_W-1]}}, a};
        bx = {{RES_W{b[RES_W-1]}}, b};
        p  = ax * bx;
        return RES_W'(p >>> RES_FRAC);
    endfunction

    state_t                  r_state, w_state_nxt;
    logic signed [RES_W-1:0] r_x, r_x2, r_acc, r_result;
    logic [2:0]              r_k;
    logic                    r_done;
    logic signed [RES_W-1:0] w_a, w_b, w_prod, w_xext, w_xcap, w_final;

`ifdef TANH_ODD_FOLD_EN
    logic                  r_neg;
    logic signed [X_W-1:0] w_dabs;

    always_comb begin
        w_dabs = bus.data_x;
        if (bus.data_x == {1'b1, {(X_W-1){1'b0}}})
            w_dabs = {1'b0, {(X_W-1){1'b1}}};
        else if (bus.data_x[X_W-1])
            w_dabs = -bus.data_x;
    end
    assign w_xext  = RES_W'(w_dabs);
    assign w_final = r_neg ? -w_prod : w_prod;
`else
    assign w_xext  = RES_W'(bus.data_x);
    assign w_final = w_prod;
`endif

    assign w_xcap = w_xext <<< SHIFT;

    // Operand steering for the single shared multiplier.
    always_comb begin
        w_a = r_x;
        w_b = r_x;
        case (r_state)
            HORNER:  begin w_a = r_acc; w_b = r_x2; end
            FINAL:   begin w_a = r_acc; w_b = r_x;  end
            default: ;
        endcase
    end
    assign w_prod = mul(w_a, w_b);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SQR;
            SQR:     w_state_nxt = (N_TERMS == 1) ? FINAL : HORNER;
            HORNER:  if (r_k == 3'd0) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x      <= '0;
            r_x2     <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
`ifdef TANH_ODD_FOLD_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_x <= w_xcap;
`ifdef TANH_ODD_FOLD_EN
                    r_neg <= bus.data_x[X_W-1];
`endif
                end
                SQR: begin
                    r_x2  <= w_prod;
                    r_acc <= COEF[N_TERMS-1];
                    r_k   <= K_INIT;
                end
                HORNER: begin
                    r_acc <= COEF[r_k] + w_prod;
                    r_k   <= r_k - 3'd1;
                end
                FINAL: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_tanh_series_core.sv
// Bench for tanh_series_core: fixed vectors, random operands and handshake corner sequences.
module tb_tanh_series_core;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic signed [16:0] data_x;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tanh_series_if #(.X_W(17), .RES_W(32)) if0 ();
    tanh_series_if #(.X_W(17), .RES_W(32)) if1 ();
    assign if0.start  = start;
    assign if0.data_x = data_x;
    assign if1.start  = start;
    assign if1.data_x = data_x;

    tanh_series_core #(.N_TERMS(5)) dut  (.clk(clk), .rst(rst), .bus(if0));
    tanh_series_core #(.N_TERMS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    real cnum [8] = '{1.0, -1.0, 2.0, -17.0, 62.0, -1382.0, 21844.0, -929569.0};
    real cden [8] = '{1.0, 3.0, 15.0, 315.0, 2835.0, 155925.0, 6081075.0, 638512875.0};

    function automatic longint rnd(real v);
        return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
    endfunction

    function automatic longint cq(int i);
        return rnd(cnum[i] / cden[i] * 1073741824.0);
    endfunction

    function automatic longint w32(longint v);
        return longint'(int'(v));
    endfunction

    // Horner on x^2 with Q2.30 values, floor-shifted products, 32-bit wrap.
    function automatic int model_raw(int xi, int nt);
        longint x, x2, acc;
        x   = longint'(xi) * 16384;
        x2  = w32((x * x) >>> 30);
        acc = cq(nt - 1);
        for (int k = nt - 2; k >= 0; k--)
            acc = w32(cq(k) + w32((acc * x2) >>> 30));
        return int'((acc * x) >>> 30);
    endfunction

    function automatic int model(int xi, int nt);
`ifdef TANH_ODD_FOLD_EN
        int ax;
        ax = (xi == -65536) ? 65535 : ((xi < 0) ? -xi : xi);
        return (xi < 0) ? -model_raw(ax, nt) : model_raw(ax, nt);
`else
        return model_raw(xi, nt);
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    // Issue one request; report both cores' results and latencies (-1 on timeout).
    task automatic op(input logic signed [16:0] x, input bit now,
                      output int res, output int lat, output int res1, output int lat1);
        if (!now) @(negedge clk);
        data_x = x;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", if0.busy, 1, 0);
        lat = -1; lat1 = -1; res = 0; res1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (if1.done && lat1 < 0) begin lat1 = c; res1 = if1.result; end
            if (if0.done) begin lat = c; res = if0.result; break; end
        end
        chk("busy_at_done", if0.busy, 0, 0);
    endtask

    typedef struct {
        logic signed [16:0] x;
        int exp;
        int exp1;
    } vec_t;

    vec_t tab [7];
    int r, l, r1, l1, ra, rb, nd;
    real xr, tv, ser;
    logic signed [16:0] rx;

    initial begin
        tab[0].x = 17'sd0;     tab[1].x = 17'sd14566;  tab[2].x = -17'sd14566;
        tab[3].x = -17'sd65536; tab[4].x = 17'sd65535; tab[5].x = 17'sd32768;
        tab[6].x = -17'sd1;
        for (int i = 0; i < 7; i++) begin
            tab[i].exp  = model(int'(tab[i].x), 5);
            tab[i].exp1 = model(int'(tab[i].x), 1);
        end

        rst = 1'b1; start = 1'b0; data_x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", if0.busy, 0, 0);
        chk("rst_done", if0.done, 0, 0);
        chk("rst_result", if0.result, 0, 0);
        chk("rst_result_n1", if1.result, 0, 0);
        rst = 1'b0;

        op(17'sd14566, 1'b0, r, l, r1, l1);
        chk("first_latency", l, 6, 0);
        chk("first_model", r, model(14566, 5), 4);
        xr = 14566.0 / 65536.0;
        tv = ($exp(2.0 * xr) - 1.0) / ($exp(2.0 * xr) + 1.0);
        chk("first_vs_tanh", r, rnd(tv * 1073741824.0), 1024);

        op(17'sd1987, 1'b1, r, l, r1, l1);
        chk("b2b_latency", l, 6, 0);
        chk("b2b_model", r, model(1987, 5), 4);
        @(posedge clk); #1;
        chk("done_one_cycle", if0.done, 0, 0);
        chk("result_held", if0.result, r, 0);

        for (int i = 0; i < 7; i++) begin
            op(tab[i].x, 1'b0, r, l, r1, l1);
            chk("tab_latency", l, 6, 0);
            chk("tab_result", r, tab[i].exp, 0);
            chk("tab_n1_latency", l1, 2, 0);
            chk("tab_n1_result", r1, tab[i].exp1, 0);
            if (tab[i].x == 17'sd0) chk("zero_exact", r, 0, 0);
            if (tab[i].x == -17'sd65536) begin
                ser = 0.0;
                for (int k = 0; k < 5; k++) ser = ser + cnum[k] / cden[k];
                chk("neg_one_series", r, rnd(-ser * 1073741824.0), 8192);
            end
        end

        for (int i = 0; i < 16; i++) begin
            rx = 17'($urandom_range(0, 131071));
            op(rx, 1'b0, r, l, r1, l1);
            chk("rand_latency", l, 6, 0);
            chk("rand_result", r, model(int'(rx), 5), 0);
            chk("rand_n1_result", r1, model(int'(rx), 1), 0);
        end

        op(17'sd14566, 1'b0, ra, l, r1, l1);
        op(-17'sd14566, 1'b0, rb, l, r1, l1);
`ifdef TANH_ODD_FOLD_EN
        chk("odd_symmetry", rb, -longint'(ra), 0);
`else
        chk("odd_symmetry", rb, -longint'(ra), 8);
`endif

        // Extra start pulses while busy must be ignored.
        @(negedge clk);
        data_x = 17'sd14566; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data_x = -17'sd20000; start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0; r = 0; l = -1;
        for (int c = 4; c <= 16; c++) begin
            @(posedge clk); #1;
            if (if0.done) begin nd++; r = if0.result; if (l < 0) l = c; end
        end
        chk("ignore_done_count", nd, 1, 0);
        chk("ignore_latency", l, 6, 0);
        chk("ignore_result", r, model(14566, 5), 0);

        // Reset during an evaluation aborts it.
        @(negedge clk);
        data_x = 17'sd1987; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", if0.busy, 0, 0);
        chk("abort_result", if0.result, 0, 0);
        chk("abort_done", if0.done, 0, 0);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (if0.done) nd++;
        end
        chk("abort_no_done", nd, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
